mem_port_arbiter: RTL and testbench

Two-requester arbiter sharing the single physical memory port of the multicycle RV32I core between the instruction-fetch path (fetch states) and the data path (load/store states). The block latches one request at a time, drives the memory port from registers, and routes mem_resp and read data back to the granted requester only. It sits between the control/datapath pair and the memory model or cache.

---
 rtl/arb_types.sv | 25 ++
 rtl/arb_pick.sv | 34 +++
 rtl/mem_port_arbiter.sv | 128 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 437 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_types.sv
// Shared types for the memory-port arbiter.
//   arb_state_t : arbiter FSM states
//   arb_src_t   : requester identity (instruction fetch or data access)
//   MBE_ALL     : byte enable driven on every read
//   word_align  : clears the byte offset of a byte address
package arb_types;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_INST,
        ARB_DATA
    } arb_state_t;

    typedef enum logic {
        SRC_INST,
        SRC_DATA
    } arb_src_t;

    localparam logic [3:0] MBE_ALL = 4'b1111;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/arb_pick.sv
// Combinational grant selection between the instruction and data requesters.
// Ports:
//   i_req, d_req  : pending requests from each source
//   last_grant    : source granted most recently
//   grant_valid   : at least one request is pending
//   grant_src     : source to grant this cycle (meaningful only with grant_valid)
// RR_EN = 1 alternates on simultaneous requests; RR_EN = 0 always favours data.
module arb_pick
    import arb_types::*;
#(
    parameter bit RR_EN = 1'b1
) (
    input  logic     i_req,
    input  logic     d_req,
    input  arb_src_t last_grant,
    output logic     grant_valid,
    output arb_src_t grant_src
);

    always_comb begin
        grant_valid = i_req | d_req;
        grant_src   = SRC_INST;
        if (i_req && d_req) begin
            if (RR_EN) begin
                grant_src = (last_grant == SRC_INST) ? SRC_DATA : SRC_INST;
            end else begin
                grant_src = SRC_DATA;
            end
        end else if (d_req) begin
            grant_src = SRC_DATA;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the instruction-fetch and load/store paths.
// One request is latched at a time; the memory port is driven from registers
// and the completion (resp + read data) is routed back to the granted side only.
// Ports:
//   clk, rst                       : clock, asynchronous active-high reset
//   i_read, i_addr                 : instruction read request and byte address
//   i_rdata, i_resp                : instruction read data and completion pulse
//   d_read, d_write, d_addr,
//   d_wdata, d_mbe                 : data request, byte address, store data/enables
//   d_rdata, d_resp                : load data and completion pulse
//   mem_read, mem_write,
//   mem_address, mem_wdata,
//   mem_byte_enable                : memory-side request (registered)
//   mem_rdata, mem_resp            : memory read data and completion pulse
module mem_port_arbiter
    import arb_types::*;
#(
    parameter bit RR_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_read,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_resp,
    input  logic        d_read,
    input  logic        d_write,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_mbe,
    output logic [31:0] d_rdata,
    output logic        d_resp,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_address,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_byte_enable,
    input  logic [31:0] mem_rdata,
    input  logic        mem_resp
);

    arb_state_t  state_q, state_d;
    arb_src_t    last_grant_q, last_grant_d;
    logic        write_q, write_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  mbe_q, mbe_d;

    logic        grant_valid;
    arb_src_t    grant_src;

    arb_pick #(
        .RR_EN(RR_EN)
    ) u_pick (
        .i_req      (i_read),
        .d_req      (d_read | d_write),
        .last_grant (last_grant_q),
        .grant_valid(grant_valid),
        .grant_src  (grant_src)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ARB_IDLE;
            last_grant_q <= SRC_INST;  // data wins the first tie
            write_q      <= 1'b0;
            addr_q       <= 32'h0;
            wdata_q      <= 32'h0;
            mbe_q        <= MBE_ALL;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            write_q      <= write_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            mbe_q        <= mbe_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        write_d      = write_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        mbe_d        = mbe_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (grant_valid) begin
                    last_grant_d = grant_src;
                    if (grant_src == SRC_DATA) begin
                        state_d = ARB_DATA;
                        addr_d  = word_align(d_addr);
                        write_d = d_write;  // write beats read if both are raised
                        wdata_d = d_wdata;
                        mbe_d   = d_write ? d_mbe : MBE_ALL;
                    end else begin
                        state_d = ARB_INST;
                        addr_d  = word_align(i_addr);
                        write_d = 1'b0;
                        mbe_d   = MBE_ALL;
                    end
                end
            end
            ARB_INST, ARB_DATA: begin
                // New requests are ignored until the memory completes.
                if (mem_resp) begin
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // Strobes decode from state flops only, so reset drops them immediately.
    always_comb begin
        mem_read        = (state_q != ARB_IDLE) && !write_q;
        mem_write       = (state_q != ARB_IDLE) && write_q;
        mem_address     = addr_q;
        mem_wdata       = wdata_q;
        mem_byte_enable = mbe_q;
        i_resp          = (state_q == ARB_INST) && mem_resp;
        d_resp          = (state_q == ARB_DATA) && mem_resp;
        i_rdata         = i_resp ? mem_rdata : 32'h0;
        d_rdata         = d_resp ? mem_rdata : 32'h0;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: one round-robin and one
// fixed-priority instance share all inputs; sel chooses which one is observed.
module tb_mem_port_arbiter;
    import arb_types::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_read, d_read, d_write, mem_resp;
    logic [31:0] i_addr, d_addr, d_wdata, mem_rdata;
    logic [3:0]  d_mbe;

    logic        mem_read_r, mem_write_r, i_resp_r, d_resp_r;
    logic [31:0] mem_address_r, mem_wdata_r, i_rdata_r, d_rdata_r;
    logic [3:0]  mem_byte_enable_r;
    logic        mem_read_f, mem_write_f, i_resp_f, d_resp_f;
    logic [31:0] mem_address_f, mem_wdata_f, i_rdata_f, d_rdata_f;
    logic [3:0]  mem_byte_enable_f;

    logic        sel = 1'b0;
    logic        s_mem_read, s_mem_write, s_i_resp, s_d_resp;
    logic [31:0] s_mem_address, s_mem_wdata, s_i_rdata, s_d_rdata;
    logic [3:0]  s_mbe;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.RR_EN(1'b1)) dut_rr (
        .clk(clk), .rst(rst), .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata_r),
        .i_resp(i_resp_r), .d_read(d_read), .d_write(d_write), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_mbe(d_mbe), .d_rdata(d_rdata_r), .d_resp(d_resp_r),
        .mem_read(mem_read_r), .mem_write(mem_write_r), .mem_address(mem_address_r),
        .mem_wdata(mem_wdata_r), .mem_byte_enable(mem_byte_enable_r),
        .mem_rdata(mem_rdata), .mem_resp(mem_resp)
    );

    mem_port_arbiter #(.RR_EN(1'b0)) dut_fp (
        .clk(clk), .rst(rst), .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata_f),
        .i_resp(i_resp_f), .d_read(d_read), .d_write(d_write), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_mbe(d_mbe), .d_rdata(d_rdata_f), .d_resp(d_resp_f),
        .mem_read(mem_read_f), .mem_write(mem_write_f), .mem_address(mem_address_f),
        .mem_wdata(mem_wdata_f), .mem_byte_enable(mem_byte_enable_f),
        .mem_rdata(mem_rdata), .mem_resp(mem_resp)
    );

    assign s_mem_read    = sel ? mem_read_f : mem_read_r;
    assign s_mem_write   = sel ? mem_write_f : mem_write_r;
    assign s_mem_address = sel ? mem_address_f : mem_address_r;
    assign s_mem_wdata   = sel ? mem_wdata_f : mem_wdata_r;
    assign s_mbe         = sel ? mem_byte_enable_f : mem_byte_enable_r;
    assign s_i_resp      = sel ? i_resp_f : i_resp_r;
    assign s_d_resp      = sel ? d_resp_f : d_resp_r;
    assign s_i_rdata     = sel ? i_rdata_f : i_rdata_r;
    assign s_d_rdata     = sel ? d_rdata_f : d_rdata_r;

    task automatic apply_reset();
        rst = 1'b1;
        i_read = 0; d_read = 0; d_write = 0; mem_resp = 0;
        i_addr = 0; d_addr = 0; d_wdata = 0; d_mbe = 0; mem_rdata = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        i_read = 0; d_read = 0; d_write = 0; mem_resp = 1;
        i_addr = 0; d_addr = 0; d_wdata = 0; d_mbe = 0; mem_rdata = 32'hA5A5_5A5A;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            sel = k[0];
            #1;
            n_cmp += 9;
            if (s_mem_read !== 1'b0) begin
                n_fail++; $display("FAIL reset_mem_read[%0d]: got %b want 0", k, s_mem_read);
            end
            if (s_mem_write !== 1'b0) begin
                n_fail++; $display("FAIL reset_mem_write[%0d]: got %b want 0", k, s_mem_write);
            end
            if (s_mem_address !== 32'h0) begin
                n_fail++; $display("FAIL reset_addr[%0d]: got %h want 0", k, s_mem_address);
            end
            if (s_mem_wdata !== 32'h0) begin
                n_fail++; $display("FAIL reset_wdata[%0d]: got %h want 0", k, s_mem_wdata);
            end
            if (s_mbe !== 4'b1111) begin
                n_fail++; $display("FAIL reset_mbe[%0d]: got %b want 1111", k, s_mbe);
            end
            if (s_i_resp !== 1'b0) begin
                n_fail++; $display("FAIL reset_i_resp[%0d]: got %b want 0", k, s_i_resp);
            end
            if (s_d_resp !== 1'b0) begin
                n_fail++; $display("FAIL reset_d_resp[%0d]: got %b want 0", k, s_d_resp);
            end
            if (s_i_rdata !== 32'h0) begin
                n_fail++; $display("FAIL reset_i_rdata[%0d]: got %h want 0", k, s_i_rdata);
            end
            if (s_d_rdata !== 32'h0) begin
                n_fail++; $display("FAIL reset_d_rdata[%0d]: got %h want 0", k, s_d_rdata);
            end
        end
        sel = 1'b0;
        mem_resp = 0;
    endtask

    task automatic test_lone_fetch();
        int rd_cnt = 0;
        int ir = 0;
        int dr = 0;
        bit drop = 0;
        sel = 0;
        apply_reset();
        i_read = 1; i_addr = 32'h0000_0062;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (drop) begin i_read = 0; drop = 0; end
            mem_resp  = s_mem_read && (rd_cnt == 2);
            mem_rdata = mem_resp ? 32'h0000_0513 : 32'hFFFF_FFFF;
            #1;
            if (s_mem_read) begin
                rd_cnt++;
                n_cmp++;
                if (s_mem_address !== 32'h0000_0060) begin
                    n_fail++; $display("FAIL fetch_addr: got %h want 00000060", s_mem_address);
                end
            end
            n_cmp++;
            if (s_i_rdata !== (s_i_resp ? 32'h0000_0513 : 32'h0)) begin
                n_fail++; $display("FAIL fetch_rdata c%0d: got %h resp %b", c, s_i_rdata, s_i_resp);
            end
            if (s_i_resp) begin ir++; drop = 1; end
            if (s_d_resp) dr++;
        end
        mem_resp = 0;
        n_cmp += 3;
        if (rd_cnt != 3) begin n_fail++; $display("FAIL fetch_rd_cycles: got %0d want 3", rd_cnt); end
        if (ir != 1) begin n_fail++; $display("FAIL fetch_i_resp_count: got %0d want 1", ir); end
        if (dr != 0) begin n_fail++; $display("FAIL fetch_d_resp_count: got %0d want 0", dr); end
    endtask

    // 0 = no strobe, 1 = instruction granted, 2 = data granted
    task automatic test_tie_rr();
        int exp_pat [12];
        int got;
        exp_pat = '{2, 0, 1, 0, 2, 0, 1, 0, 2, 0, 1, 0};
        sel = 0;
        apply_reset();
        i_read = 1; d_read = 1; i_addr = 32'h1000; d_addr = 32'h2000;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            mem_resp  = s_mem_read;
            mem_rdata = 32'h1234_0000 + c;
            #1;
            got = !s_mem_read ? 0 : (s_mem_address == 32'h2000 ? 2 : 1);
            n_cmp += 3;
            if (got != exp_pat[c]) begin
                n_fail++; $display("FAIL rr_grant c%0d: got %0d want %0d", c, got, exp_pat[c]);
            end
            if (s_i_resp !== (exp_pat[c] == 1)) begin
                n_fail++; $display("FAIL rr_i_resp c%0d: got %b", c, s_i_resp);
            end
            if (s_d_resp !== (exp_pat[c] == 2)) begin
                n_fail++; $display("FAIL rr_d_resp c%0d: got %b", c, s_d_resp);
            end
        end
        mem_resp = 0;
    endtask

    task automatic test_fixed();
        int exp_pat [12];
        int got;
        exp_pat = '{2, 0, 2, 0, 2, 0, 2, 0, 2, 0, 1, 0};
        sel = 1;
        apply_reset();
        i_read = 1; d_read = 1; i_addr = 32'h1000; d_addr = 32'h2000;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (c == 9) d_read = 0;
            mem_resp  = s_mem_read;
            mem_rdata = 32'h5678_0000 + c;
            #1;
            got = !s_mem_read ? 0 : (s_mem_address == 32'h2000 ? 2 : 1);
            n_cmp += 2;
            if (got != exp_pat[c]) begin
                n_fail++; $display("FAIL fp_grant c%0d: got %0d want %0d", c, got, exp_pat[c]);
            end
            if (s_i_resp !== (exp_pat[c] == 1)) begin
                n_fail++; $display("FAIL fp_i_resp c%0d: got %b", c, s_i_resp);
            end
        end
        mem_resp = 0;
        sel = 0;
    endtask

    task automatic test_store();
        int wr_cnt = 0;
        int dr = 0;
        bit drop = 0;
        sel = 0;
        apply_reset();
        d_write = 1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF; d_mbe = 4'b0011;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (drop) begin d_write = 0; drop = 0; end
            if (wr_cnt >= 1) d_wdata = 32'h0;
            mem_resp = s_mem_write && (wr_cnt == 2);
            #1;
            if (s_mem_write) begin
                wr_cnt++;
                n_cmp += 4;
                if (s_mem_wdata !== 32'hDEAD_BEEF) begin
                    n_fail++; $display("FAIL store_wdata: got %h want deadbeef", s_mem_wdata);
                end
                if (s_mbe !== 4'b0011) begin
                    n_fail++; $display("FAIL store_mbe: got %b want 0011", s_mbe);
                end
                if (s_mem_address !== 32'h100) begin
                    n_fail++; $display("FAIL store_addr: got %h want 00000100", s_mem_address);
                end
                if (s_mem_read !== 1'b0) begin
                    n_fail++; $display("FAIL store_read_strobe: got %b want 0", s_mem_read);
                end
            end
            if (s_d_resp) begin dr++; drop = 1; end
        end
        mem_resp = 0;
        n_cmp += 2;
        if (wr_cnt != 3) begin n_fail++; $display("FAIL store_wr_cycles: got %0d want 3", wr_cnt); end
        if (dr != 1) begin n_fail++; $display("FAIL store_d_resp_count: got %0d want 1", dr); end
    endtask

    task automatic test_mid_reset();
        sel = 0;
        apply_reset();
        d_read = 1; d_addr = 32'h300; i_addr = 32'h1000;
        repeat (2) @(negedge clk);
        #1;
        n_cmp++;
        if (s_mem_read !== 1'b1) begin
            n_fail++; $display("FAIL midrst_pre_read: got %b want 1", s_mem_read);
        end
        #1;
        rst = 1'b1;
        #1;
        n_cmp += 3;
        if (s_mem_read !== 1'b0) begin
            n_fail++; $display("FAIL midrst_read_drop: got %b want 0", s_mem_read);
        end
        if (s_mem_write !== 1'b0) begin
            n_fail++; $display("FAIL midrst_write_drop: got %b want 0", s_mem_write);
        end
        if (s_d_resp !== 1'b0) begin
            n_fail++; $display("FAIL midrst_d_resp: got %b want 0", s_d_resp);
        end
        @(negedge clk);
        i_read = 1;
        rst = 1'b0;
        @(negedge clk);
        #1;
        n_cmp += 2;
        if (s_mem_read !== 1'b1) begin
            n_fail++; $display("FAIL midrst_post_read: got %b want 1", s_mem_read);
        end
        if (s_mem_address !== 32'h300) begin
            n_fail++; $display("FAIL midrst_first_tie: got %h want 00000300", s_mem_address);
        end
    endtask

    task automatic test_spurious();
        sel = 0;
        apply_reset();
        mem_resp = 1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            mem_rdata = $urandom;
            #1;
            n_cmp += 4;
            if (s_i_resp !== 1'b0 || s_d_resp !== 1'b0) begin
                n_fail++; $display("FAIL spur_resp: got i=%b d=%b want 0", s_i_resp, s_d_resp);
            end
            if (s_mem_read !== 1'b0 || s_mem_write !== 1'b0) begin
                n_fail++; $display("FAIL spur_strobe: got r=%b w=%b want 0", s_mem_read, s_mem_write);
            end
            if (s_i_rdata !== 32'h0) begin
                n_fail++; $display("FAIL spur_i_rdata: got %h want 0", s_i_rdata);
            end
            if (s_d_rdata !== 32'h0) begin
                n_fail++; $display("FAIL spur_d_rdata: got %h want 0", s_d_rdata);
            end
        end
        @(negedge clk);
        mem_resp = 0; i_read = 1; i_addr = 32'h0000_0041;
        @(negedge clk);
        #1;
        n_cmp += 2;
        if (s_mem_read !== 1'b1) begin
            n_fail++; $display("FAIL spur_then_fetch: got %b want 1", s_mem_read);
        end
        if (s_mem_address !== 32'h0000_0040) begin
            n_fail++; $display("FAIL spur_fetch_addr: got %h want 00000040", s_mem_address);
        end
    endtask

    // Transaction-level reference: one outstanding access, chosen from the
    // requests visible at the idle edge, completing when memory responds.
    task automatic test_random(input bit s);
        bit          exp_busy = 0;
        bit          exp_wr = 0;
        arb_src_t    exp_src = SRC_INST;
        arb_src_t    last = SRC_INST;
        arb_src_t    prev_src = SRC_INST;
        logic [31:0] exp_addr = 0, exp_wdata = 0;
        logic [3:0]  exp_mbe = 4'hF;
        bit          snap_i = 0, snap_d = 0, snap_wr = 0, prev_resp = 0;
        logic [31:0] snap_ia = 0, snap_da = 0, snap_wd = 0;
        logic [3:0]  snap_mbe = 0;
        int          lat = 1, cnt = 0, gap_i = 0, gap_d = 0, op;
        bit          exp_ir, exp_dr;
        sel = s;
        apply_reset();
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (exp_busy) begin
                if (prev_resp) exp_busy = 0;
            end else if (snap_i || snap_d) begin
                if (snap_i && snap_d) begin
                    if (s == 1'b0) exp_src = (last == SRC_INST) ? SRC_DATA : SRC_INST;
                    else           exp_src = SRC_DATA;
                end else begin
                    exp_src = snap_d ? SRC_DATA : SRC_INST;
                end
                last = exp_src;
                exp_busy = 1;
                if (exp_src == SRC_DATA) begin
                    exp_addr  = snap_da & ~32'h3;
                    exp_wr    = snap_wr;
                    exp_wdata = snap_wd;
                    exp_mbe   = snap_wr ? snap_mbe : 4'hF;
                end else begin
                    exp_addr = snap_ia & ~32'h3;
                    exp_wr   = 0;
                    exp_mbe  = 4'hF;
                end
                lat = $urandom_range(1, 4);
                cnt = 0;
            end
            if (prev_resp && prev_src == SRC_INST) begin
                i_read = 0; gap_i = $urandom_range(0, 2);
            end
            if (prev_resp && prev_src == SRC_DATA) begin
                d_read = 0; d_write = 0; gap_d = $urandom_range(0, 2);
            end
            if (!i_read) begin
                if (gap_i > 0) gap_i--;
                else if ($urandom_range(0, 1) == 1) begin i_read = 1; i_addr = $urandom; end
            end
            if (!d_read && !d_write) begin
                if (gap_d > 0) gap_d--;
                else if ($urandom_range(0, 1) == 1) begin
                    op = $urandom_range(0, 2);
                    d_read  = (op != 1);
                    d_write = (op != 0);
                    d_addr  = $urandom;
                    d_wdata = $urandom;
                    d_mbe   = 4'($urandom);
                end
            end
            mem_rdata = $urandom;
            if (exp_busy) begin
                cnt++;
                mem_resp = (cnt == lat);
            end else begin
                mem_resp = ($urandom_range(0, 7) == 0);
            end
            snap_i = i_read; snap_d = d_read | d_write; snap_wr = d_write;
            snap_ia = i_addr; snap_da = d_addr; snap_wd = d_wdata; snap_mbe = d_mbe;
            #1;
            exp_ir = exp_busy && mem_resp && exp_src == SRC_INST;
            exp_dr = exp_busy && mem_resp && exp_src == SRC_DATA;
            n_cmp += 6;
            if (s_mem_read !== (exp_busy && !exp_wr)) begin
                n_fail++; $display("FAIL rnd%0d_read c%0d: got %b", s, c, s_mem_read);
            end
            if (s_mem_write !== (exp_busy && exp_wr)) begin
                n_fail++; $display("FAIL rnd%0d_write c%0d: got %b", s, c, s_mem_write);
            end
            if (s_i_resp !== exp_ir) begin
                n_fail++; $display("FAIL rnd%0d_i_resp c%0d: got %b want %b", s, c, s_i_resp, exp_ir);
            end
            if (s_d_resp !== exp_dr) begin
                n_fail++; $display("FAIL rnd%0d_d_resp c%0d: got %b want %b", s, c, s_d_resp, exp_dr);
            end
            if (s_i_rdata !== (exp_ir ? mem_rdata : 32'h0)) begin
                n_fail++; $display("FAIL rnd%0d_i_rdata c%0d: got %h", s, c, s_i_rdata);
            end
            if (s_d_rdata !== (exp_dr ? mem_rdata : 32'h0)) begin
                n_fail++; $display("FAIL rnd%0d_d_rdata c%0d: got %h", s, c, s_d_rdata);
            end
            if (exp_busy) begin
                n_cmp += 2;
                if (s_mem_address !== exp_addr) begin
                    n_fail++;
                    $display("FAIL rnd%0d_addr c%0d: got %h want %h", s, c, s_mem_address, exp_addr);
                end
                if (s_mbe !== exp_mbe) begin
                    n_fail++; $display("FAIL rnd%0d_mbe c%0d: got %b want %b", s, c, s_mbe, exp_mbe);
                end
                if (exp_wr) begin
                    n_cmp++;
                    if (s_mem_wdata !== exp_wdata) begin
                        n_fail++;
                        $display("FAIL rnd%0d_wdata c%0d: got %h want %h", s, c, s_mem_wdata,
                                 exp_wdata);
                    end
                end
            end
            prev_resp = exp_busy && mem_resp;
            prev_src  = exp_src;
        end
        mem_resp = 0;
    endtask

    initial begin
        test_reset();
        test_lone_fetch();
        test_tie_rr();
        test_fixed();
        test_store();
        test_mid_reset();
        test_spurious();
        test_random(1'b0);
        test_random(1'b1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
